// File: rtl/assoc_cache_controller.sv
`default_nettype none
// ============================================================================
// assoc_cache_controller : 2-way set-associative write-back/write-allocate
// cache controller with per-set LRU and burst refill/writeback.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module assoc_cache_controller #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2,
    parameter int STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_up,
    input  logic                  write_up,
    input  logic [ADDR_WIDTH-1:0] addr_up,
    input  logic [DATA_WIDTH-1:0] wdata_up,
    output logic [DATA_WIDTH-1:0] rdata_up,
    output logic                  stall_up,
    output logic                  done_up,
    output logic                  read_mem,
    output logic                  write_mem,
    output logic [ADDR_WIDTH-1:0] addr_mem,
    output logic [DATA_WIDTH-1:0] wdata_mem,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    input  logic                  ready_mem,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count
);
    localparam int SETS        = 1 << INDEX_BITS;
    localparam int BLOCK_WORDS = 1 << OFFSET_BITS;
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } state_t;

    state_t                  state;
    logic [OFFSET_BITS-1:0]  beat;
    logic                    victim;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic [SETS-1:0]         valid [2];
    logic [SETS-1:0]         dirty [2];
    logic [SETS-1:0]         lru;
    logic [TAG_BITS-1:0]     tags     [2][SETS];
    logic [DATA_WIDTH-1:0]   data_arr [2][SETS][BLOCK_WORDS];

    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_index;
    logic [OFFSET_BITS-1:0]  req_offset;
    logic [1:0]              way_hit;
    logic                    hit;
    logic                    hit_way;
    logic                    miss_victim;
    logic [TAG_BITS-1:0]     mv_tag;
    logic [TAG_BITS-1:0]     vic_tag;
    logic [OFFSET_BITS-1:0]  beat_next;
    logic                    last_beat;

    assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_index  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_offset = req_addr[OFFSET_BITS-1:0];

    assign way_hit[0] = valid[0][req_index] && (tags[0][req_index] == req_tag);
    assign way_hit[1] = valid[1][req_index] && (tags[1][req_index] == req_tag);
    assign hit        = |way_hit;
    assign hit_way    = way_hit[1];

    // Invalid ways are filled first (way 0 before way 1); otherwise evict the LRU way.
    assign miss_victim = !valid[0][req_index] ? 1'b0 :
                         !valid[1][req_index] ? 1'b1 : lru[req_index];
    assign mv_tag      = tags[miss_victim][req_index];
    assign vic_tag     = tags[victim][req_index];
    assign beat_next   = beat + 1'b1;
    assign last_beat   = (beat == {OFFSET_BITS{1'b1}});

    assign done_up  = (state == COMPARE) && hit;
    assign rdata_up = done_up ? data_arr[hit_way][req_index][req_offset] : '0;
    assign stall_up = (read_up | write_up) & ~done_up;

`ifdef CACHE_STATS_EN
    logic refilled;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            victim    <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            valid[0]  <= '0;
            valid[1]  <= '0;
            dirty[0]  <= '0;
            dirty[1]  <= '0;
            lru       <= '0;
            read_mem  <= 1'b0;
            write_mem <= 1'b0;
            addr_mem  <= '0;
            wdata_mem <= '0;
`ifdef CACHE_STATS_EN
            refilled  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (read_up || write_up) begin
                        req_write <= write_up;
                        req_addr  <= addr_up;
                        req_wdata <= wdata_up;
`ifdef CACHE_STATS_EN
                        refilled  <= 1'b0;
`endif
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_write)
                            dirty[hit_way][req_index] <= 1'b1;
                        lru[req_index] <= ~hit_way;
                        state          <= IDLE;
                    end else begin
                        victim <= miss_victim;
                        beat   <= '0;
                        if (valid[miss_victim][req_index] && dirty[miss_victim][req_index]) begin
                            write_mem <= 1'b1;
                            addr_mem  <= {mv_tag, req_index, {OFFSET_BITS{1'b0}}};
                            wdata_mem <= data_arr[miss_victim][req_index][0];
                            state     <= WRITEBACK;
                        end else begin
                            read_mem <= 1'b1;
                            addr_mem <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
                            state    <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (ready_mem) begin
                        if (last_beat) begin
                            beat      <= '0;
                            write_mem <= 1'b0;
                            wdata_mem <= '0;
                            read_mem  <= 1'b1;
                            addr_mem  <= {req_tag, req_index, {OFFSET_BITS{1'b0}}};
                            state     <= REFILL;
                        end else begin
                            beat      <= beat_next;
                            addr_mem  <= {vic_tag, req_index, beat_next};
                            wdata_mem <= data_arr[victim][req_index][beat_next];
                        end
                    end
                end
                REFILL: begin
                    if (ready_mem) begin
                        if (last_beat) begin
                            beat                     <= '0;
                            read_mem                 <= 1'b0;
                            addr_mem                 <= '0;
                            valid[victim][req_index] <= 1'b1;
                            dirty[victim][req_index] <= 1'b0;
`ifdef CACHE_STATS_EN
                            refilled                 <= 1'b1;
`endif
                            state                    <= COMPARE;
                        end else begin
                            beat     <= beat_next;
                            addr_mem <= {req_tag, req_index, beat_next};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage arrays carry no reset; valid bits alone decide whether contents are used.
    always_ff @(posedge clk) begin
        if (state == COMPARE && hit && req_write)
            data_arr[hit_way][req_index][req_offset] <= req_wdata;
        else if (state == REFILL && ready_mem)
            data_arr[victim][req_index][beat] <= rdata_mem;
        if (state == REFILL && ready_mem && last_beat)
            tags[victim][req_index] <= req_tag;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE && !refilled) begin
            if (hit && hit_count != {STAT_WIDTH{1'b1}})
                hit_count <= hit_count + 1'b1;
            if (!hit && miss_count != {STAT_WIDTH{1'b1}})
                miss_count <= miss_count + 1'b1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire
